// File: rtl/maxpool_stage.sv
// maxpool_stage: 2x2 stride-2 signed int8 max pooling over packed 64-bit BRAM words.
// Define MAXPOOL_RELU_EN to clamp every pooled byte at zero.
module maxpool_stage #(
  parameter int ADDR_W     = 12,
  parameter int ROW_STRIDE = 128,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [7:0]        row_words,
  input  logic [6:0]        row_pairs,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [63:0]       rd_data,
  output logic              we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [63:0]       wr_data
);

  localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(ROW_STRIDE);
  localparam logic [ADDR_W-1:0] STRIDE2 = ADDR_W'(2 * ROW_STRIDE);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  localparam int unused_rd_lat = RD_LAT;

  typedef enum logic [2:0] {
    IDLE, RD0, RD1, RD2, RD3, CAP, WR, DONE
  } state_t;

  state_t state, nxt;

  logic [ADDR_W-1:0] in_row, out_row;
  logic [ADDR_W-1:0] top0, bot0;
  logic [6:0]        cols, rows, c, r;
  logic [63:0]       t0_q, b0_q, t1_q, pooled;
  logic              go, c_last, r_last;
  logic              unused_bit;

  assign unused_bit = row_words[0];
  assign go     = start && (row_words[7:1] != 7'd0)
                        && (row_pairs != 7'd0);
  assign c_last = (c == cols - 7'd1);
  assign r_last = (r == rows - 7'd1);
  assign top0   = in_row + ADDR_W'({c, 1'b0});
  assign bot0   = top0 + STRIDE;

  function automatic logic [7:0] pool4(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] d,
    input logic [7:0] e
  );
    logic signed [7:0] m;
    m = $signed(a);
    if ($signed(b) > m) m = $signed(b);
    if ($signed(d) > m) m = $signed(d);
    if ($signed(e) > m) m = $signed(e);
`ifdef MAXPOOL_RELU_EN
    if (m[7]) m = '0;
`endif
    return m;
  endfunction

  // bot1 is consumed straight off rd_data in CAP
  always_comb begin
    pooled = '0;
    for (int j = 0; j < 4; j++) begin
      pooled[63-8*j -: 8] = pool4(
        t0_q[63-16*j -: 8], t0_q[55-16*j -: 8],
        b0_q[63-16*j -: 8], b0_q[55-16*j -: 8]);
      pooled[31-8*j -: 8] = pool4(
        t1_q[63-16*j -: 8], t1_q[55-16*j -: 8],
        rd_data[63-16*j -: 8], rd_data[55-16*j -: 8]);
    end
  end

  always_comb begin
    nxt     = state;
    rd_en   = 1'b0;
    rd_addr = '0;
    we      = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (go) nxt = RD0;
      end
      RD0: begin
        rd_en   = 1'b1;
        rd_addr = top0;
        nxt     = RD1;
      end
      RD1: begin
        rd_en   = 1'b1;
        rd_addr = bot0;
        nxt     = RD2;
      end
      RD2: begin
        rd_en   = 1'b1;
        rd_addr = top0 + ONE;
        nxt     = RD3;
      end
      RD3: begin
        rd_en   = 1'b1;
        rd_addr = bot0 + ONE;
        nxt     = CAP;
      end
      CAP: nxt = WR;
      WR: begin
        we  = 1'b1;
        nxt = (c_last && r_last) ? DONE : RD0;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      in_row  <= '0;
      out_row <= '0;
      cols    <= '0;
      rows    <= '0;
      c       <= '0;
      r       <= '0;
      t0_q    <= '0;
      b0_q    <= '0;
      t1_q    <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: begin
          if (go) begin
            in_row  <= in_base;
            out_row <= out_base;
            cols    <= row_words[7:1];
            rows    <= row_pairs;
            c       <= '0;
            r       <= '0;
          end
        end
        RD1: t0_q <= rd_data;
        RD2: b0_q <= rd_data;
        RD3: t1_q <= rd_data;
        CAP: begin
          wr_addr <= out_row + ADDR_W'(c);
          wr_data <= pooled;
        end
        WR: begin
          if (c_last) begin
            c       <= '0;
            r       <= r + 7'd1;
            in_row  <= in_row + STRIDE2;
            out_row <= out_row + STRIDE;
          end else begin
            c <= c + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_stage.sv
// tb_maxpool_stage: directed bench with a pixel-level pooling model
// and a per-cycle compare process for reads, writes and held outputs.
module tb_maxpool_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] in_base = '0;
  logic [11:0] out_base = '0;
  logic [7:0]  row_words = '0;
  logic [6:0]  row_pairs = '0;
  logic        busy, done, rd_en, we;
  logic [11:0] rd_addr, wr_addr;
  logic [63:0] rd_data = '0;
  logic [63:0] wr_data;
  logic        rst_q = 1'b0;

  logic [63:0] mem [0:4095];

  logic [11:0] exp_rd[$];
  logic [11:0] exp_wa[$];
  logic [63:0] exp_wd[$];
  logic [11:0] rd_log[$];
  logic [11:0] wr_log[$];
  logic [11:0] hold_a = '0;
  logic [63:0] hold_d = '0;
  logic [63:0] last_wd = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr = 0;

`ifdef MAXPOOL_RELU_EN
  localparam logic [63:0] EXP1 = 64'h0806_0608_7F00_0020;
  localparam logic [63:0] EXP2 = 64'h0000_0000_0000_0000;
  localparam logic [63:0] EXP3 = 64'h0000_0000_0000_0000;
`else
  localparam logic [63:0] EXP1 = 64'h0806_0608_7F00_FF20;
  localparam logic [63:0] EXP2 = 64'hFF80_8080_8080_8080;
  localparam logic [63:0] EXP3 = 64'hF0F0_F0F0_F0F0_F0F0;
`endif

  maxpool_stage dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_base(in_base),
    .out_base(out_base),
    .row_words(row_words),
    .row_pairs(row_pairs),
    .busy(busy),
    .done(done),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .we(we),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rst_q <= rst;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event want none", name);
  endtask

  function automatic int px(input logic [63:0] w, input int i);
    logic [7:0] x;
    x = w[63-8*i -: 8];
    return int'($signed(x));
  endfunction

  // output pixel q pools pixels 2q,2q+1 of the top/bottom word pair
  function automatic logic [63:0] pool_word(input logic [63:0] t0,
                                            input logic [63:0] b0,
                                            input logic [63:0] t1,
                                            input logic [63:0] b1);
    logic [63:0] res, a, b;
    int p, m;
    res = '0;
    for (int q = 0; q < 8; q++) begin
      a = (q < 4) ? t0 : t1;
      b = (q < 4) ? b0 : b1;
      p = 2 * (q % 4);
      m = -1000;
      for (int s = 0; s < 2; s++) begin
        if (px(a, p + s) > m) m = px(a, p + s);
        if (px(b, p + s) > m) m = px(b, p + s);
      end
`ifdef MAXPOOL_RELU_EN
      if (m < 0) m = 0;
`endif
      res[63-8*q -: 8] = 8'(m);
    end
    return res;
  endfunction

  task automatic expect_job(input int ib, input int ob,
                            input int rw, input int rp);
    int t0, b0, t1, b1;
    for (int r = 0; r < rp; r++) begin
      for (int c = 0; c < rw / 2; c++) begin
        t0 = (ib + 2 * r * 128 + 2 * c) % 4096;
        b0 = (t0 + 128) % 4096;
        t1 = (t0 + 1) % 4096;
        b1 = (b0 + 1) % 4096;
        exp_rd.push_back(12'(t0));
        exp_rd.push_back(12'(b0));
        exp_rd.push_back(12'(t1));
        exp_rd.push_back(12'(b1));
        exp_wa.push_back(12'((ob + r * 128 + c) % 4096));
        exp_wd.push_back(pool_word(mem[t0], mem[b0],
                                   mem[t1], mem[b1]));
      end
    end
  endtask

  initial begin
    logic [11:0] ea;
    logic [63:0] ed;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        chk("rst_ctrl", {busy, done, rd_en, we}, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        hold_a = '0;
        hold_d = '0;
      end else begin
        if (rd_en) begin
          rd_log.push_back(rd_addr);
          if (exp_rd.size() == 0) note_fail("rd_unexpected");
          else chk("rd_addr", rd_addr, exp_rd.pop_front());
        end
        if (we) begin
          n_wr++;
          wr_log.push_back(wr_addr);
          last_wd = wr_data;
          if (exp_wa.size() == 0) begin
            note_fail("wr_unexpected");
          end else begin
            ea = exp_wa.pop_front();
            ed = exp_wd.pop_front();
            chk("wr_addr", wr_addr, ea);
            chk("wr_data", wr_data, ed);
            hold_a = ea;
            hold_d = ed;
          end
        end else begin
          chk("hold_addr", wr_addr, hold_a);
          chk("hold_data", wr_data, hold_d);
        end
        if (done) chk("done_drained", exp_wa.size(), 0);
      end
    end
  end

  task automatic run_job(input int ib, input int ob,
                         input int rw, input int rp,
                         input int restart_at, input int abort_at,
                         output int lat, output int bcnt,
                         output int nwr);
    int wr0;
    wr0 = n_wr;
    expect_job(ib, ob, rw, rp);
    @(posedge clk); #1;
    in_base   = 12'(ib);
    out_base  = 12'(ob);
    row_words = 8'(rw);
    row_pairs = 7'(rp);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (1'b1) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) break;
      if (lat == restart_at) begin
        start   = 1'b1;
        in_base = 12'h400;
      end
      if (lat == restart_at + 1) start = 1'b0;
      if (lat == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd.delete();
        exp_wa.delete();
        exp_wd.delete();
        break;
      end
      if (lat > 20000) begin
        note_fail("timeout");
        break;
      end
    end
    nwr = n_wr - wr0;
  endtask

  initial begin
    int lat, bc, nw, b, viol, w0, r0;
    for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_ctrl", {busy, done, rd_en, we}, 0);

    mem[0]   = 64'h0102_0304_0506_0708;
    mem[128] = 64'h0807_0605_0403_0201;
    mem[1]   = 64'h7F80_0000_FFFE_1020;
    mem[129] = 64'h7F80_0000_FFFE_1020;
    chk("model_pin1", pool_word(mem[0], mem[128],
                                mem[1], mem[129]), EXP1);
    run_job(0, 'h800, 2, 1, -1, -1, lat, bc, nw);
    chk("t1_done_lat", lat, 7);
    chk("t1_busy", bc, 6);
    chk("t1_writes", nw, 1);
    chk("t1_addr", wr_log[wr_log.size()-1], 12'h800);
    chk("t1_data", last_wd, EXP1);
    @(negedge clk);
    chk("t1_done_pulse", {done, busy}, 0);

    mem['h010] = 64'h8080_8080_8080_8080;
    mem['h090] = 64'h80FF_8080_8080_8080;
    mem['h011] = 64'h8080_8080_8080_8080;
    mem['h091] = 64'h8080_8080_8080_8080;
    chk("model_pin2", pool_word(mem['h010], mem['h090],
                                mem['h011], mem['h091]), EXP2);
    run_job('h010, 'h810, 2, 1, -1, -1, lat, bc, nw);
    chk("signed_data", last_wd, EXP2);

    mem['h020] = 64'hF0F0_F0F0_F0F0_F0F0;
    mem['h0A0] = 64'hF0F0_F0F0_F0F0_F0F0;
    mem['h021] = 64'hF0F0_F0F0_F0F0_F0F0;
    mem['h0A1] = 64'hF0F0_F0F0_F0F0_F0F0;
    run_job('h020, 'h818, 2, 1, -1, -1, lat, bc, nw);
    chk("relu_data", last_wd, EXP3);

    b  = wr_log.size();
    r0 = rd_log.size();
    run_job('h100, 'h800, 8, 3, -1, -1, lat, bc, nw);
    chk("sweep_writes", nw, 12);
    chk("sweep_busy", bc, 72);
    chk("sweep_lat", lat, 73);
    chk("sweep_wa0", wr_log[b], 12'h800);
    chk("sweep_wa4", wr_log[b+4], 12'h880);
    chk("sweep_wa11", wr_log[b+11], 12'h903);
    chk("sweep_ra0", rd_log[r0], 12'h100);
    chk("sweep_ra1", rd_log[r0+1], 12'h180);
    chk("sweep_ra3", rd_log[r0+3], 12'h181);
    chk("sweep_ra4", rd_log[r0+4], 12'h102);

    viol = 0;
    r0 = rd_log.size();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      row_words = (k == 1) ? 8'd1 : ((k == 2) ? 8'd0 : 8'd4);
      row_pairs = (k == 0) ? 7'd0 : 7'd2;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (busy || rd_en || done || we) viol++;
      end
    end
    chk("illegal_quiet", viol, 0);
    chk("illegal_reads", rd_log.size() - r0, 0);

    run_job('h200, 'h820, 4, 1, 3, -1, lat, bc, nw);
    chk("overlap_writes", nw, 2);
    chk("overlap_lat", lat, 13);
    w0 = n_wr;
    repeat (12) @(negedge clk);
    chk("overlap_after", n_wr - w0, 0);

    w0 = n_wr;
    r0 = rd_log.size();
    run_job('h300, 'h840, 4, 1, -1, 9, lat, bc, nw);
    @(negedge clk);
    chk("abort_quiet", {busy, done, rd_en, we}, 0);
    repeat (10) @(negedge clk);
    chk("abort_writes", n_wr - w0, 1);
    chk("abort_reads", rd_log.size() - r0, 7);
    chk("abort_last_wa", wr_log[wr_log.size()-1], 12'h840);
    run_job('h300, 'h840, 4, 1, -1, -1, lat, bc, nw);
    chk("restart_writes", nw, 2);
    chk("restart_lat", lat, 13);

    r0 = rd_log.size();
    run_job('hFFF, 'h800, 2, 1, -1, -1, lat, bc, nw);
    chk("wrap_ra0", rd_log[r0], 12'hFFF);
    chk("wrap_ra1", rd_log[r0+1], 12'h07F);
    chk("wrap_ra2", rd_log[r0+2], 12'h000);
    chk("wrap_ra3", rd_log[r0+3], 12'h080);
    chk("wrap_writes", nw, 1);

    repeat (4) @(negedge clk);
    chk("rd_q_empty", exp_rd.size(), 0);
    chk("wr_q_empty", exp_wa.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
